// File: rtl/bfloat_max_tracker.sv
// Streaming bfloat16 max/argmax reduction with valid/ready handshakes on both sides.
// Optional NaN detection and canonicalisation is enabled by defining BF_MAX_NAN_EN.
module bfloat_max_tracker #(
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_max,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W:0]   out_cnt,
  output logic             out_ovf,
  output logic             out_nan
);

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  localparam logic [IDX_W:0] CntMax = {1'b1, {IDX_W{1'b0}}};

  // Sign-magnitude ordering code: 00 equal, 01 a>b, 10 a<b.
  function automatic logic [1:0] bf_cmp(input logic [15:0] a, input logic [15:0] b);
    logic [1:0] code;
    if (a[14:0] == 15'd0 && b[14:0] == 15'd0) begin
      code = 2'b00;
    end else if (a[15] != b[15]) begin
      code = a[15] ? 2'b10 : 2'b01;
    end else if (a[14:0] == b[14:0]) begin
      code = 2'b00;
    end else if (!a[15]) begin
      code = (a[14:0] > b[14:0]) ? 2'b01 : 2'b10;
    end else begin
      code = (a[14:0] < b[14:0]) ? 2'b01 : 2'b10;
    end
    return code;
  endfunction

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [15:0]      max_q, max_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] nidx_q, nidx_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             accept;
  logic [1:0]       code;

`ifdef BF_MAX_NAN_EN
  logic nan_q, nan_d;
  logic in_nan;
  assign in_nan = (in_data[14:7] == 8'hFF) && (in_data[6:0] != 7'd0);
`endif

  assign accept = in_valid && in_ready_q;
  assign code   = bf_cmp(in_data, max_q);

  always_comb begin
    state_d    = state_q;
    in_ready_d = in_ready_q;
    max_d      = max_q;
    idx_d      = idx_q;
    nidx_d     = nidx_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
`ifdef BF_MAX_NAN_EN
    nan_d      = nan_q;
`endif
    unique case (state_q)
      StIdle: begin
        in_ready_d = 1'b1;
        if (accept) begin
          max_d  = in_data;
          idx_d  = '0;
          cnt_d  = (IDX_W+1)'(1);
          nidx_d = IDX_W'(1);
          ovf_d  = 1'b0;
`ifdef BF_MAX_NAN_EN
          nan_d  = 1'b0;
          if (in_nan) begin
            max_d = 16'h7FC0;
            nan_d = 1'b1;
          end
`endif
          if (in_last) begin
            state_d    = StHold;
            in_ready_d = 1'b0;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        in_ready_d = 1'b1;
        if (accept) begin
`ifdef BF_MAX_NAN_EN
          // Once a NaN has been captured it owns the result for the rest of the vector.
          if (!nan_q) begin
            if (in_nan) begin
              max_d = 16'h7FC0;
              idx_d = nidx_q;
              nan_d = 1'b1;
            end else if (code == 2'b01) begin
              max_d = in_data;
              idx_d = nidx_q;
            end
          end
`else
          if (code == 2'b01) begin
            max_d = in_data;
            idx_d = nidx_q;
          end
`endif
          if (cnt_q == CntMax) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + (IDX_W+1)'(1);
          end
          nidx_d = nidx_q + IDX_W'(1);
          if (in_last) begin
            state_d    = StHold;
            in_ready_d = 1'b0;
          end
        end
      end
      StHold: begin
        in_ready_d = 1'b0;
        if (out_ready) begin
          state_d    = StIdle;
          in_ready_d = 1'b1;
          ovf_d      = 1'b0;
`ifdef BF_MAX_NAN_EN
          nan_d      = 1'b0;
`endif
        end
      end
      default: begin
        state_d    = StIdle;
        in_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      in_ready_q <= 1'b0;
      max_q      <= 16'h0000;
      idx_q      <= '0;
      nidx_q     <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
`ifdef BF_MAX_NAN_EN
      nan_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      max_q      <= max_d;
      idx_q      <= idx_d;
      nidx_q     <= nidx_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
`ifdef BF_MAX_NAN_EN
      nan_q      <= nan_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == StHold);
  assign out_max   = max_q;
  assign out_idx   = idx_q;
  assign out_cnt   = cnt_q;
  assign out_ovf   = ovf_q;
`ifdef BF_MAX_NAN_EN
  assign out_nan   = nan_q;
`else
  assign out_nan   = 1'b0;
`endif

endmodule

// File: tb/tb_bfloat_max_tracker.sv
// Randomized and directed bench for bfloat_max_tracker against a value-level max/argmax model.
module tb_bfloat_max_tracker;
  localparam int unsigned IDX_W = 8;
  localparam int unsigned VMax  = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_max;
  logic [IDX_W-1:0] out_idx;
  logic [IDX_W:0]   out_cnt;
  logic             out_ovf;
  logic             out_nan;

  always #5 clk = ~clk;

  bfloat_max_tracker #(.IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_idx   (out_idx),
    .out_cnt   (out_cnt),
    .out_ovf   (out_ovf),
    .out_nan   (out_nan)
  );

  int n_total = 0;
  int n_bad   = 0;

  logic [15:0]      vec[$];
  logic [15:0]      r_max;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W:0]   r_cnt;
  logic             r_nan;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Map sign-magnitude encoding onto a signed integer line; +0 and -0 both land on 0.
  function automatic int key(input logic [15:0] x);
    int mag;
    mag = int'(x[14:0]);
    return x[15] ? -mag : mag;
  endfunction

  function automatic logic is_nan(input logic [15:0] x);
    return (x[14:7] == 8'hFF) && (x[6:0] != 7'd0);
  endfunction

  task automatic model(output logic [15:0] m, output int idx, output logic nan);
    m   = vec[0];
    idx = 0;
    nan = 1'b0;
    for (int k = 1; k < vec.size(); k++) begin
      if (key(vec[k]) > key(m)) begin
        m   = vec[k];
        idx = k;
      end
    end
`ifdef BF_MAX_NAN_EN
    for (int k = 0; k < vec.size(); k++) begin
      if (is_nan(vec[k])) begin
        m   = 16'h7FC0;
        idx = k;
        nan = 1'b1;
        break;
      end
    end
`endif
  endtask

  function automatic logic [15:0] rnd_sample();
    case ($urandom_range(7))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return 16'h7F80;
      3:       return 16'hFF80;
      4:       return 16'h3F80;
      5:       return 16'hBF80;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic run_vec(input int gap_pct, input int hold_cycles);
    int          i = 0;
    int          budget = 0;
    int          n;
    logic [15:0] e_max;
    int          e_idx;
    logic        e_nan;
    int          e_cnt;
    n = vec.size();
    while (i < n && budget < 5000) begin
      @(negedge clk);
      budget++;
      if (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 16'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = vec[i];
        in_last  = (i == n - 1);
        if (in_ready) i++;
      end
    end
    if (i < n) begin
      check("input_timeout", 32'(i), 32'(n));
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    model(e_max, e_idx, e_nan);
    e_cnt = (n > int'(VMax)) ? int'(VMax) : n;
    check("out_valid_after_last", 32'(out_valid), 32'd1);
    check("in_ready_in_hold", 32'(in_ready), 32'd0);
    check("out_max", 32'(out_max), 32'(e_max));
    check("out_cnt", 32'(out_cnt), 32'(e_cnt));
    check("out_ovf", 32'(out_ovf), 32'(n > int'(VMax)));
    check("out_nan", 32'(out_nan), 32'(e_nan));
    if (n <= int'(VMax)) check("out_idx", 32'(out_idx), 32'(e_idx));
    r_max = out_max;
    r_idx = out_idx;
    r_cnt = out_cnt;
    r_nan = out_nan;
    for (int h = 0; h < hold_cycles; h++) begin
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      in_last  = 1'($urandom);
      @(negedge clk);
      check("hold_stable", {5'd0, out_valid, in_ready, out_max, out_cnt},
            {5'd0, 1'b1, 1'b0, e_max, 9'(e_cnt)});
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("ready_after_handshake", {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_values", {6'd0, in_ready, out_valid, out_max, out_cnt[7:0]}, 32'd0);
    check("reset_idx_flags", {22'd0, out_idx, out_ovf, out_nan}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", 32'(in_ready), 32'd1);

    vec = '{16'h3F80, 16'h4000, 16'h3F00};
    run_vec(0, 0);
    check("t1_max", 32'(r_max), 32'h4000);
    check("t1_idx", 32'(r_idx), 32'd1);
    check("t1_cnt", 32'(r_cnt), 32'd3);

    vec = '{16'hC000, 16'hBF80, 16'hC040};
    run_vec(0, 1);
    check("neg_max", 32'(r_max), 32'hBF80);
    check("neg_idx", 32'(r_idx), 32'd1);

    vec = '{16'h8000, 16'h0000, 16'h3F80, 16'h3F80};
    run_vec(0, 0);
    check("tie_max", 32'(r_max), 32'h3F80);
    check("tie_idx", 32'(r_idx), 32'd2);

    vec = '{16'h8000};
    run_vec(0, 5);
    check("single_max", 32'(r_max), 32'h8000);
    check("single_idx", 32'(r_idx), 32'd0);
    check("single_cnt", 32'(r_cnt), 32'd1);

    // Abort a vector with reset after two accepted samples.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h7000;
    in_last  = 1'b0;
    @(negedge clk);
    in_data  = 16'h7100;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    check("midreset_values", {6'd0, in_ready, out_valid, out_max, out_cnt[7:0]}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_ready", 32'(in_ready), 32'd1);
    vec = '{16'h3F00};
    run_vec(0, 0);
    check("midreset_max", 32'(r_max), 32'h3F00);
    check("midreset_idx", 32'(r_idx), 32'd0);
    check("midreset_cnt", 32'(r_cnt), 32'd1);

    vec = '{16'h3F80, 16'h7FC1, 16'h4000};
    run_vec(0, 0);
`ifdef BF_MAX_NAN_EN
    check("nan_max", 32'(r_max), 32'h7FC0);
    check("nan_flag", 32'(r_nan), 32'd1);
`else
    check("nan_max", 32'(r_max), 32'h7FC1);
    check("nan_flag", 32'(r_nan), 32'd0);
`endif
    check("nan_idx", 32'(r_idx), 32'd1);

    vec.delete();
    for (int k = 0; k < int'(VMax) + 2; k++) vec.push_back(rnd_sample());
    run_vec(0, 0);

    for (int t = 0; t < 40; t++) begin
      int len;
      len = int'($urandom_range(12, 1));
      vec.delete();
      for (int k = 0; k < len; k++) vec.push_back(rnd_sample());
      run_vec(30, int'($urandom_range(3)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
